reg_spill_unit: RTL and testbench

REG_SPILL_UNIT -- requirements
Module: reg_spill_unit

---
 rtl/reg_spill_unit_pkg.sv | 23 ++
 rtl/reg_spill_unit.sv | 160 ++++++++++++++++
 tb/tb_reg_spill_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_spill_unit_pkg.sv
// reg_spill_unit_pkg
//   Shared widths and the FSM state encoding for the register spill unit.
//   clamp_count() limits a requested spill length to the register file size.
package reg_spill_unit_pkg;

   localparam int DATA_W   = 24;
   localparam int ADDR_W   = 24;
   localparam int REGIDX_W = 4;
   localparam int NUM_REGS = 16;
   localparam int COUNT_W  = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] cnt);
      return (cnt > COUNT_W'(NUM_REGS)) ? COUNT_W'(NUM_REGS) : cnt;
   endfunction

endpackage

// File: rtl/reg_spill_unit.sv
// reg_spill_unit
//   Copies a contiguous range of register-file entries out to memory, one
//   word per READ/SEND pair. Register index wraps mod 16, memory address
//   wraps mod 2^24.
//
// Ports
//   Clock     in   rising-edge clock
//   Reset     in   synchronous active-high reset (overrides Start)
//   Start     in   spill request, accepted only while idle
//   BaseReg   in   [3:0]  first register index
//   Count     in   [4:0]  words to spill, values above 16 clamp to 16
//   BaseAddr  in   [23:0] memory word address of the first word
//   RegAddr   out  [3:0]  register file read index (0 outside READ)
//   RegData   in   [23:0] register file read data, combinational from RegAddr
//   MemValid  out  write request valid (SEND only)
//   MemReady  in   write request accepted
//   MemAddr   out  [23:0] write address, stable while MemValid
//   MemData   out  [23:0] write data, stable while MemValid
//   Busy      out  high whenever not idle
//   Done      out  one-cycle completion pulse
//   Checksum  out  [23:0] XOR of words written in the current spill
//                  (only when REG_SPILL_CHECKSUM_EN is defined)
//
// Optional feature macro: REG_SPILL_CHECKSUM_EN
module reg_spill_unit
   import reg_spill_unit_pkg::*;
(
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Start,
   input  logic [3:0]          BaseReg,
   input  logic [4:0]          Count,
   input  logic [23:0]         BaseAddr,
   output logic [3:0]          RegAddr,
   input  logic [23:0]         RegData,
   output logic                MemValid,
   input  logic                MemReady,
   output logic [23:0]         MemAddr,
   output logic [23:0]         MemData,
   output logic                Busy,
   output logic                Done
`ifdef REG_SPILL_CHECKSUM_EN
   ,
   output logic [23:0]         Checksum
`endif
);

   state_t              r_state;
   logic [REGIDX_W-1:0] r_base_reg;
   logic [COUNT_W-1:0]  r_count;
   logic [ADDR_W-1:0]   r_base_addr;
   logic [COUNT_W-1:0]  r_k;
   logic [REGIDX_W-1:0] r_reg_addr;
   logic                r_mem_valid;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_data;
   logic                r_busy;
   logic                r_done;
`ifdef REG_SPILL_CHECKSUM_EN
   logic [DATA_W-1:0]   r_checksum;
`endif

   logic [COUNT_W-1:0]  w_count_clamped;
   logic [COUNT_W-1:0]  w_k_next;
   logic                w_more;
   logic [REGIDX_W-1:0] w_next_idx;
   logic                w_handshake;

   assign w_count_clamped = clamp_count(Count);
   assign w_k_next        = r_k + COUNT_W'(1);
   assign w_more          = (w_k_next < r_count);
   // Index of the register read after this handshake; 4-bit add wraps 15->0.
   assign w_next_idx      = r_base_reg + r_k[REGIDX_W-1:0] + REGIDX_W'(1);
   assign w_handshake     = r_mem_valid && MemReady;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state     <= ST_IDLE;
         r_base_reg  <= '0;
         r_count     <= '0;
         r_base_addr <= '0;
         r_k         <= '0;
         r_reg_addr  <= '0;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_data  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef REG_SPILL_CHECKSUM_EN
         r_checksum  <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (Start) begin
                  r_base_reg  <= BaseReg;
                  r_count     <= w_count_clamped;
                  r_base_addr <= BaseAddr;
                  r_k         <= '0;
                  r_busy      <= 1'b1;
`ifdef REG_SPILL_CHECKSUM_EN
                  r_checksum  <= '0;
`endif
                  if (w_count_clamped != '0) begin
                     r_state    <= ST_READ;
                     // RegAddr is registered, so it is loaded on entry to READ.
                     r_reg_addr <= BaseReg;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               r_mem_data  <= RegData;
               r_mem_addr  <= r_base_addr + ADDR_W'(r_k);
               r_mem_valid <= 1'b1;
               r_reg_addr  <= '0;
               r_state     <= ST_SEND;
            end
            ST_SEND: begin
               if (w_handshake) begin
                  r_mem_valid <= 1'b0;
                  r_k         <= w_k_next;
`ifdef REG_SPILL_CHECKSUM_EN
                  r_checksum  <= r_checksum ^ r_mem_data;
`endif
                  if (w_more) begin
                     r_state    <= ST_READ;
                     r_reg_addr <= w_next_idx;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign RegAddr  = r_reg_addr;
   assign MemValid = r_mem_valid;
   assign MemAddr  = r_mem_addr;
   assign MemData  = r_mem_data;
   assign Busy     = r_busy;
   assign Done     = r_done;
`ifdef REG_SPILL_CHECKSUM_EN
   assign Checksum = r_checksum;
`endif

endmodule

// File: tb/tb_reg_spill_unit.sv
module tb_reg_spill_unit;

   logic        Clock = 1'b0;
   logic        Reset, Start, MemReady;
   logic [3:0]  BaseReg, RegAddr;
   logic [4:0]  Count;
   logic [23:0] BaseAddr, RegData, MemAddr, MemData;
   logic        MemValid, Busy, Done;
`ifdef REG_SPILL_CHECKSUM_EN
   logic [23:0] Checksum;
`endif

   logic [23:0] regs [16];
   assign RegData = regs[RegAddr];

   reg_spill_unit dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .BaseReg(BaseReg),
      .Count(Count), .BaseAddr(BaseAddr), .RegAddr(RegAddr), .RegData(RegData),
      .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr),
      .MemData(MemData), .Busy(Busy), .Done(Done)
`ifdef REG_SPILL_CHECKSUM_EN
      , .Checksum(Checksum)
`endif
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int failures = 0;
   logic [47:0] exp_q[$];
   logic [47:0] got_q[$];
   logic [3:0]  ra_q[$];
   int          done_cnt = 0;
   int          viol = 0;
   logic [23:0] exp_cks;

   // Monitor: inputs change at posedge+1, so the negedge sees a settled cycle.
   always @(negedge Clock) begin
      if (MemValid && MemReady && !Reset) got_q.push_back({MemAddr, MemData});
      if (Done === 1'b1) done_cnt++;
      if (Busy === 1'b1 && MemValid === 1'b0 && Done === 1'b0) ra_q.push_back(RegAddr);
      else if (RegAddr !== 4'd0 && Reset === 1'b0) viol++;
      if (MemValid === 1'b1 && Busy !== 1'b1) viol++;
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic clear_obs();
      exp_q.delete(); got_q.delete(); ra_q.delete();
      done_cnt = 0;
   endtask

   task automatic do_start(input logic [3:0] b, input logic [4:0] c, input logic [23:0] a);
      BaseReg = b; Count = c; BaseAddr = a; Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic push_model(input logic [3:0] b, input logic [4:0] c, input logic [23:0] a);
      int n;
      logic [3:0]  idx;
      logic [23:0] ad;
      n = (c > 5'd16) ? 16 : int'(c);
      exp_cks = 24'h0;
      for (int i = 0; i < n; i++) begin
         idx = b + 4'(i);
         ad  = a + 24'(i);
         exp_q.push_back({ad, regs[idx]});
         exp_cks ^= regs[idx];
      end
   endtask

   task automatic wait_done(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (Done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b1; MemReady = 1'b1;
      BaseReg = 4'd1; Count = 5'd3; BaseAddr = 24'h000010;
      tick(); tick();
      Start = 1'b0;
      checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", Busy); end
      checks++; if (MemValid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", MemValid); end
      checks++; if (Done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", Done); end
      checks++; if (MemAddr !== 24'h0 || MemData !== 24'h0) begin failures++; $display("FAIL rst_mem got=%h/%h exp=0/0", MemAddr, MemData); end
      checks++; if (RegAddr !== 4'd0) begin failures++; $display("FAIL rst_regaddr got=%0d exp=0", RegAddr); end
`ifdef REG_SPILL_CHECKSUM_EN
      checks++; if (Checksum !== 24'h0) begin failures++; $display("FAIL rst_cks got=%h exp=0", Checksum); end
`endif
      Reset = 1'b0;
      tick();
      checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_start_prio busy got=%b exp=0", Busy); end
   endtask

   task automatic test_basic();
      bit ok;
      logic [47:0] g;
      clear_obs();
      regs[2] = 24'h111111; regs[3] = 24'h222222; regs[4] = 24'h333333;
      exp_q.push_back({24'h000100, 24'h111111});
      exp_q.push_back({24'h000101, 24'h222222});
      exp_q.push_back({24'h000102, 24'h333333});
      MemReady = 1'b1;
      do_start(4'd2, 5'd3, 24'h000100);
      checks++; if (MemValid !== 1'b0 || Busy !== 1'b1) begin failures++; $display("FAIL basic_read_cycle valid/busy got=%b/%b exp=0/1", MemValid, Busy); end
      checks++; if (RegAddr !== 4'd2) begin failures++; $display("FAIL basic_regaddr got=%0d exp=2", RegAddr); end
      tick();
      checks++; if (MemValid !== 1'b1 || MemAddr !== 24'h000100) begin failures++; $display("FAIL basic_first_valid got=%b/%h exp=1/000100", MemValid, MemAddr); end
      wait_done(40, ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=0 exp=1"); end
`ifdef REG_SPILL_CHECKSUM_EN
      checks++; if (Checksum !== 24'h000000) begin failures++; $display("FAIL basic_cks got=%h exp=000000", Checksum); end
`endif
      tick();
      checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL basic_idle busy/done got=%b/%b exp=0/0", Busy, Done); end
      checks++; if (got_q.size() != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         checks++; if (g !== exp_q[0]) begin failures++; $display("FAIL basic_word got=%h exp=%h", g, exp_q[0]); end
         void'(exp_q.pop_front());
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_wrap();
      bit ok;
      logic [47:0] g;
      logic [3:0] exp_ra [4];
      exp_ra[0] = 4'd14; exp_ra[1] = 4'd15; exp_ra[2] = 4'd0; exp_ra[3] = 4'd1;
      clear_obs();
      for (int i = 0; i < 16; i++) regs[i] = 24'hA00000 + 24'(i * 24'h010101);
      push_model(4'd14, 5'd4, 24'hFFFFFE);
      MemReady = 1'b1;
      do_start(4'd14, 5'd4, 24'hFFFFFE);
      wait_done(40, ok);
      checks++; if (!ok) begin failures++; $display("FAIL wrap_done_timeout got=0 exp=1"); end
`ifdef REG_SPILL_CHECKSUM_EN
      checks++; if (Checksum !== exp_cks) begin failures++; $display("FAIL wrap_cks got=%h exp=%h", Checksum, exp_cks); end
`endif
      tick();
      checks++; if (ra_q.size() != 4) begin failures++; $display("FAIL wrap_ra_count got=%0d exp=4", ra_q.size()); end
      for (int i = 0; i < 4 && i < ra_q.size(); i++) begin
         checks++; if (ra_q[i] !== exp_ra[i]) begin failures++; $display("FAIL wrap_regaddr[%0d] got=%0d exp=%0d", i, ra_q[i], exp_ra[i]); end
      end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         checks++; if (g !== exp_q[0]) begin failures++; $display("FAIL wrap_word got=%h exp=%h", g, exp_q[0]); end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_stall();
      clear_obs();
      regs[5] = 24'h5A5A5A;
      MemReady = 1'b0;
      do_start(4'd5, 5'd1, 24'h000ABC);
      tick();
      checks++; if (MemValid !== 1'b1 || MemAddr !== 24'h000ABC || MemData !== 24'h5A5A5A) begin
         failures++; $display("FAIL stall_first got=%b/%h/%h exp=1/000abc/5a5a5a", MemValid, MemAddr, MemData); end
      regs[5] = 24'h000001;   // a later register write must not leak into the pending word
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (MemValid !== 1'b1 || MemAddr !== 24'h000ABC || MemData !== 24'h5A5A5A) begin
            failures++; $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/000abc/5a5a5a", i, MemValid, MemAddr, MemData); end
      end
      MemReady = 1'b1;
      tick();
      checks++; if (Done !== 1'b1 || MemValid !== 1'b0) begin failures++; $display("FAIL stall_complete done/valid got=%b/%b exp=1/0", Done, MemValid); end
      checks++; if (got_q.size() != 1) begin failures++; $display("FAIL stall_count got=%0d exp=1", got_q.size()); end
      tick();
   endtask

   task automatic test_count_limits();
      bit ok;
      logic [47:0] g;
      clear_obs();
      MemReady = 1'b1;
      do_start(4'd3, 5'd0, 24'h000010);
      checks++; if (Done !== 1'b1 || MemValid !== 1'b0) begin failures++; $display("FAIL zero_done done/valid got=%b/%b exp=1/0", Done, MemValid); end
      tick();
      checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL zero_idle done/busy got=%b/%b exp=0/0", Done, Busy); end
      tick();
      checks++; if (got_q.size() != 0 || done_cnt != 1) begin failures++; $display("FAIL zero_words words/dones got=%0d/%0d exp=0/1", got_q.size(), done_cnt); end

      clear_obs();
      for (int i = 0; i < 16; i++) regs[i] = 24'h300000 ^ 24'(i * 24'h000F11);
      push_model(4'd7, 5'd20, 24'h000400);
      do_start(4'd7, 5'd20, 24'h000400);
      wait_done(100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL clamp_done_timeout got=0 exp=1"); end
`ifdef REG_SPILL_CHECKSUM_EN
      checks++; if (Checksum !== exp_cks) begin failures++; $display("FAIL clamp_cks got=%h exp=%h", Checksum, exp_cks); end
`endif
      tick();
      checks++; if (got_q.size() != 16) begin failures++; $display("FAIL clamp_count got=%0d exp=16", got_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         checks++; if (g !== exp_q[0]) begin failures++; $display("FAIL clamp_word got=%h exp=%h", g, exp_q[0]); end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_busy_start();
      bit ok;
      logic [47:0] g;
      clear_obs();
      for (int i = 0; i < 16; i++) regs[i] = 24'h0C0000 + 24'(i);
      push_model(4'd0, 5'd3, 24'h000300);
      MemReady = 1'b1;
      do_start(4'd0, 5'd3, 24'h000300);
      tick();
      BaseReg = 4'd9; Count = 5'd7; BaseAddr = 24'h00F000; Start = 1'b1;
      tick();
      Start = 1'b0;
      wait_done(40, ok);
      checks++; if (!ok) begin failures++; $display("FAIL busy_done_timeout got=0 exp=1"); end
      repeat (6) tick();
      checks++; if (got_q.size() != 3 || done_cnt != 1) begin failures++; $display("FAIL busy_ignored words/dones got=%0d/%0d exp=3/1", got_q.size(), done_cnt); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         checks++; if (g !== exp_q[0]) begin failures++; $display("FAIL busy_word got=%h exp=%h", g, exp_q[0]); end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_reset_mid();
      int n;
      clear_obs();
      MemReady = 1'b1;
      do_start(4'd0, 5'd5, 24'h000200);
      n = 0;
      while (got_q.size() < 2 && n < 40) begin tick(); n++; end
      checks++; if (got_q.size() != 2) begin failures++; $display("FAIL rstmid_reach got=%0d exp=2", got_q.size()); end
      Reset = 1'b1;
      tick();
      checks++; if (MemValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
         failures++; $display("FAIL rstmid_state valid/busy/done got=%b/%b/%b exp=0/0/0", MemValid, Busy, Done); end
      Reset = 1'b0;
      repeat (10) tick();
      checks++; if (got_q.size() != 2 || done_cnt != 0) begin failures++; $display("FAIL rstmid_after words/dones got=%0d/%0d exp=2/0", got_q.size(), done_cnt); end
   endtask

`ifdef REG_SPILL_CHECKSUM_EN
   task automatic test_checksum();
      bit ok;
      clear_obs();
      regs[6] = 24'h0F0F0F; regs[7] = 24'h00FF00;
      MemReady = 1'b1;
      do_start(4'd6, 5'd2, 24'h000000);
      wait_done(40, ok);
      checks++; if (!ok || Checksum !== 24'h0FF00F) begin failures++; $display("FAIL cks_value got=%h exp=0ff00f", Checksum); end
      repeat (3) tick();
      checks++; if (Checksum !== 24'h0FF00F) begin failures++; $display("FAIL cks_hold got=%h exp=0ff00f", Checksum); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 24'h0;
      Reset = 1'b1; Start = 1'b0; MemReady = 1'b0;
      BaseReg = 4'd0; Count = 5'd0; BaseAddr = 24'h0;
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_count_limits();
      test_busy_start();
      test_reset_mid();
`ifdef REG_SPILL_CHECKSUM_EN
      test_checksum();
`endif
      checks++; if (viol != 0) begin failures++; $display("FAIL idle_outputs violations got=%0d exp=0", viol); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
